uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (8-bit, start/stop/parity framing handled downstream) between NUM_REQ packet sources: status reporter, ADC telemetry, command echo and debug.
- Round-robin arbitration at packet granularity: a granted source keeps the transmitter until its last byte completes.
- Sequences the transmitter's start/done handshake.
- Per-source byte acknowledge.
- Watchdog recovers from a stalled transmitter or an abandoned packet.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLK_FREQ, 50000000, system clock in Hz (informational, used for TIMEOUT_CLKS default)
TIMEOUT_CLKS, 1000000, cycles allowed in WAIT_DONE or HOLD before forced release (20 ms @ 50 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
req  in  NUM_REQ  per-source byte valid; held until req_ack
req_last  in  NUM_REQ  per-source: current byte is last of packet; qualified by req
req_data  in  8*NUM_REQ  per-source byte; source i at bits [8i+7:8i]
req_ack  out  NUM_REQ  one-cycle pulse: byte of source i accepted
grant  out  NUM_REQ  one-hot owner of transmitter; all-zero when idle
tx_start  out  1  one-cycle pulse to transmitter
tx_data  out  8  byte to transmitter; stable from tx_start until tx_done
tx_busy  in  1  transmitter busy
tx_done  in  1  one-cycle pulse: stop bit finished
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async): state=IDLE, grant=0, req_ack=0, tx_start=0, tx_data=8'h00, timeout_err=0, rr_ptr=0, wdog=0, last_flag=0.
- States: IDLE, LOAD, WAIT_DONE, HOLD.
- IDLE: when |req and !tx_busy, choose the first asserted source scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Set grant one-hot, go to LOAD. If tx_busy is set, stay in IDLE.
- LOAD (exactly 1 cycle):
  - tx_data <= req_data[g], tx_start <= 1, req_ack[g] <= 1, last_flag <= req_last[g].
  - Go to WAIT_DONE, wdog <= 0.
  - Pulses are registered: visible the cycle after LOAD, for 1 cycle.
- WAIT_DONE: wdog increments each cycle. On tx_done:
  - last_flag=1 -> grant <= 0, rr_ptr <= (g+1) mod NUM_REQ, IDLE.
  - last_flag=0 and req[g]=1 -> LOAD.
  - last_flag=0 and req[g]=0 -> HOLD, wdog <= 0.
- HOLD: grant retained; other sources are blocked. req[g]=1 -> LOAD. wdog increments.
- Watchdog: wdog == TIMEOUT_CLKS-1 in WAIT_DONE or HOLD -> timeout_err pulse, grant <= 0, rr_ptr <= g+1, IDLE. A tx_done arriving in the same cycle takes priority: normal transition, no error.
- Latency: req rising in IDLE at cycle n -> grant at n+1, tx_start/req_ack at n+2. Back-to-back bytes of one packet: tx_done at cycle m -> next tx_start at m+2.
- req deasserted by a non-granted source has no effect. A req deasserted by the granted source before ack is treated as a HOLD condition.
- tx_done outside WAIT_DONE is ignored.
- req_ack is never asserted for more than one source, nor for more than one cycle per byte.
- Width: wdog is clog2(TIMEOUT_CLKS)+1 bits. rr_ptr is clog2(NUM_REQ) bits and wraps NUM_REQ-1 -> 0 explicitly (NUM_REQ need not be a power of 2).
- Reset mid-packet: immediate return to IDLE, all outputs per reset. The transmitter is reset by the same signal.

Optional Feature:
UART_ARB_PRIO0_EN:
- Defined: source 0 wins every IDLE arbitration when req[0]=1, regardless of rr_ptr. Sources 1..NUM_REQ-1 remain round-robin among themselves. No preemption of a packet in progress.
- Undefined: pure round-robin over all sources.

Test Plan:
1. Single source 1 sends packet {0x55, 0xAA, 0x0F}, last on 0x0F; model tx_done 20 cycles after each tx_start -> three tx_start with tx_data 0x55, 0xAA, 0x0F; three req_ack[1] pulses; grant=4'b0010 throughout, 0 after third tx_done; rr_ptr=2.
2. Sources 0, 2, 3 each request a 1-byte packet (0x10, 0x30, 0x40) simultaneously from reset -> transmit order 0x10, 0x30, 0x40. Repeating the requests gives the same order.
3. Source 2 is mid-packet (0xA1 not last); source 0 requests -> source 0 is not granted until source 2's last byte 0xA2 completes. Then 0x0? from source 0 is sent.
4. Transmitter never asserts tx_done, TIMEOUT_CLKS=100 -> timeout_err pulse 100 cycles after WAIT_DONE entry, grant=0, next requester served.
5. Source 1 drops req after a non-last byte for 50 cycles (TIMEOUT_CLKS=100) -> HOLD, no other grant, resume on req. With a 150-cycle gap -> timeout_err.
6. reset asserted 3 cycles after tx_start -> all outputs 0 asynchronously, state IDLE. With UART_ARB_PRIO0_EN, sources 0 and 1 requesting together -> source 0 granted twice in a row.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: source request/ack bundle plus transmitter start/done handshake.
// master = arbiter side, slave = sources and transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_last;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   grant;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 timeout_err;

    modport master (
        input  req, req_last, req_data, tx_busy, tx_done,
        output req_ack, grant, tx_start, tx_data, timeout_err
    );

    modport slave (
        output req, req_last, req_data, tx_busy, tx_done,
        input  req_ack, grant, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter with watchdog.
// Define UART_ARB_PRIO0_EN to let source 0 win every idle arbitration it takes part in.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLK_FREQ     = 50000000,
    parameter int TIMEOUT_CLKS = CLK_FREQ / 50
) (
    input logic               clk,
    input logic               reset,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT_CLKS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, HOLD} state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] grant_q, ack_q;
    logic [PW-1:0]      rr_ptr_q, g_q, pick_d, rr_d;
    logic [WW-1:0]      wdog_q;
    logic [7:0]         data_q;
    logic               start_q, terr_q, last_flag_q, found_d, expired_d;

    assign bus.grant       = grant_q;
    assign bus.req_ack     = ack_q;
    assign bus.tx_start    = start_q;
    assign bus.tx_data     = data_q;
    assign bus.timeout_err = terr_q;

    // First requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        pick_d  = rr_ptr_q;
        found_d = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found_d && bus.req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                pick_d  = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
                found_d = 1'b1;
            end
        end
`ifdef UART_ARB_PRIO0_EN
        if (bus.req[0]) pick_d = '0;
`else
`endif
    end

    assign rr_d      = (g_q == PW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
    assign expired_d = wdog_q == WW'(TIMEOUT_CLKS - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            data_q      <= 8'h00;
            terr_q      <= 1'b0;
            rr_ptr_q    <= '0;
            g_q         <= '0;
            wdog_q      <= '0;
            last_flag_q <= 1'b0;
        end else begin
            ack_q   <= '0;
            start_q <= 1'b0;
            terr_q  <= 1'b0;
            case (state_q)
                IDLE: if (|bus.req && !bus.tx_busy) begin
                    g_q     <= pick_d;
                    grant_q <= NUM_REQ'(1) << pick_d;
                    state_q <= LOAD;
                end
                LOAD: begin
                    data_q      <= bus.req_data[int'(g_q) * 8 +: 8];
                    start_q     <= 1'b1;
                    ack_q       <= grant_q;
                    last_flag_q <= bus.req_last[g_q];
                    wdog_q      <= '0;
                    state_q     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (bus.tx_done) begin
                        if (last_flag_q) begin
                            grant_q  <= '0;
                            rr_ptr_q <= rr_d;
                            state_q  <= IDLE;
                        end else if (bus.req[g_q]) begin
                            state_q <= LOAD;
                        end else begin
                            wdog_q  <= '0;
                            state_q <= HOLD;
                        end
                    end else if (expired_d) begin
                        terr_q   <= 1'b1;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_d;
                        state_q  <= IDLE;
                    end
                end
                HOLD: begin
                    wdog_q <= wdog_q + 1'b1;
                    if (bus.req[g_q]) begin
                        state_q <= LOAD;
                    end else if (expired_d) begin
                        terr_q   <= 1'b1;
                        grant_q  <= '0;
                        rr_ptr_q <= rr_d;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
